// File: rtl/pi_loop_sequencer.sv
// Iteration sequencer for the PI control loop: takes one ADC sample per
// iteration, holds pipeline operands, stores the clamped integral and publishes.
module pi_loop_sequencer #(
  parameter int INPUT_WIDTH      = 18,
  parameter int OUTPUT_WIDTH     = 32,
  parameter int INTEGRAL_LATENCY = 2,
  parameter int PIPELINE_LATENCY = 6,
  parameter logic signed [OUTPUT_WIDTH-1:0] INTEGRAL_LIMIT = 32'sh3FFFFFFF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           clear_integral,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  input  logic signed [INPUT_WIDTH-1:0]  sample,
  input  logic signed [INPUT_WIDTH-1:0]  setpoint_in,
  input  logic signed [OUTPUT_WIDTH-1:0] kp_in,
  input  logic signed [OUTPUT_WIDTH-1:0] ki_in,
  output logic signed [INPUT_WIDTH-1:0]  pipe_actual,
  output logic signed [INPUT_WIDTH-1:0]  pipe_setpoint,
  output logic signed [OUTPUT_WIDTH-1:0] pipe_kp,
  output logic signed [OUTPUT_WIDTH-1:0] pipe_ki,
  output logic signed [OUTPUT_WIDTH-1:0] pipe_integral_input,
  input  logic signed [OUTPUT_WIDTH-1:0] pipe_integral_result,
  input  logic signed [OUTPUT_WIDTH-1:0] pipe_pi_result,
  output logic                           out_valid,
  output logic signed [OUTPUT_WIDTH-1:0] out_value,
  output logic                           busy,
  output logic [31:0]                    iteration_count,
  output logic [1:0]                     dbg_state_o,
  output logic signed [OUTPUT_WIDTH-1:0] dbg_integral_o
);

  localparam int CW = $clog2(PIPELINE_LATENCY + 1);
  localparam logic [CW-1:0] CNT_INT = CW'(INTEGRAL_LATENCY);
  localparam logic [CW-1:0] CNT_PUB = CW'(PIPELINE_LATENCY);
  localparam logic signed [OUTPUT_WIDTH-1:0] LIM_POS = INTEGRAL_LIMIT;
  localparam logic signed [OUTPUT_WIDTH-1:0] LIM_NEG = -INTEGRAL_LIMIT;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_SAMPLE = 2'd1,
    WAIT_PIPE   = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic signed [OUTPUT_WIDTH-1:0] integ_q, integ_d;
  logic                      clr_pend_q, clr_pend_d;
  logic signed [INPUT_WIDTH-1:0]  actual_q, actual_d, setpt_q, setpt_d;
  logic signed [OUTPUT_WIDTH-1:0] kp_q, kp_d, ki_q, ki_d, integ_in_q, integ_in_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [OUTPUT_WIDTH-1:0] out_value_q, out_value_d;
  logic [31:0]               iter_q, iter_d;
  logic signed [OUTPUT_WIDTH-1:0] integ_clamped;

  // Handshake: a sample transfers on any rising edge where sample_valid and
  // sample_ready are both high; sample_ready is high only in WAIT_SAMPLE.
  assign sample_ready        = (state_q == WAIT_SAMPLE);
  assign busy                = (state_q == WAIT_PIPE);
  assign pipe_actual         = actual_q;
  assign pipe_setpoint       = setpt_q;
  assign pipe_kp             = kp_q;
  assign pipe_ki             = ki_q;
  assign pipe_integral_input = integ_in_q;
  assign out_valid           = out_valid_q;
  assign out_value           = out_value_q;
  assign iteration_count     = iter_q;
  assign dbg_state_o         = state_q;
  assign dbg_integral_o      = integ_q;

  always_comb begin
    if (pipe_integral_result > LIM_POS)      integ_clamped = LIM_POS;
    else if (pipe_integral_result < LIM_NEG) integ_clamped = LIM_NEG;
    else                                     integ_clamped = pipe_integral_result;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    integ_d     = integ_q;
    clr_pend_d  = clr_pend_q;
    actual_d    = actual_q;
    setpt_d     = setpt_q;
    kp_d        = kp_q;
    ki_d        = ki_q;
    integ_in_d  = integ_in_q;
    out_valid_d = 1'b0;
    out_value_d = out_value_q;
    iter_d      = iter_q;
    case (state_q)
      IDLE: begin
        if (clear_integral) integ_d = '0;
        if (enable) state_d = WAIT_SAMPLE;
      end
      WAIT_SAMPLE: begin
        if (clear_integral) integ_d = '0;
        if (sample_valid) begin
          actual_d   = sample;
          setpt_d    = setpoint_in;
          kp_d       = kp_in;
          ki_d       = ki_in;
          // A clear arriving with the sample starts this iteration from zero.
          integ_in_d = clear_integral ? '0 : integ_q;
          cnt_d      = '0;
          state_d    = WAIT_PIPE;
        end else if (!enable) begin
          state_d = IDLE;
        end
      end
      WAIT_PIPE: begin
        cnt_d = cnt_q + CW'(1);
        if (clear_integral) clr_pend_d = 1'b1;
        if (cnt_q == CNT_INT) integ_d = integ_clamped;
        if (cnt_q == CNT_PUB) begin
          out_value_d = pipe_pi_result;
          out_valid_d = 1'b1;
          iter_d      = iter_q + 32'd1;
          // Pending clear wins over the captured integral; published value is untouched.
          if (clr_pend_q || clear_integral) integ_d = '0;
          clr_pend_d  = 1'b0;
          cnt_d       = '0;
          state_d     = enable ? WAIT_SAMPLE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      integ_q     <= '0;
      clr_pend_q  <= 1'b0;
      actual_q    <= '0;
      setpt_q     <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      integ_in_q  <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      iter_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      integ_q     <= integ_d;
      clr_pend_q  <= clr_pend_d;
      actual_q    <= actual_d;
      setpt_q     <= setpt_d;
      kp_q        <= kp_d;
      ki_q        <= ki_d;
      integ_in_q  <= integ_in_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      iter_q      <= iter_d;
    end
  end

endmodule
